ram_arbiter: RTL and testbench

- Shares the 16x8 program/data RAM between two requesters: port 0 (control unit: fetch, LDA/STA-style accesses) and port 1 (program loader / debug port).
- Sequences every access as address setup (MAR), then a bus read or write, then an acknowledge pulse.
- Drives the RAM's address, read and write strobes, and the write-data driver onto the shared 8-bit bus.
- Arbitrates with round-robin or fixed priority.

---
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the shared program/data RAM.
// Every access runs IDLE -> ADDR -> ACCESS -> DONE; the granted port's ack pulses in DONE.
module ram_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [DATA_W-1:0] bus_in,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              tie;
  logic              win1;

  // last_q names the port that won the previous tie; the other one wins the next.
  always_comb begin
    tie  = req0 && req1;
    win1 = 1'b0;
    if (req1 && !req0)
      win1 = 1'b1;
    else if (tie && FIXED_PRIO == 0)
      win1 = ~last_q;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          state_d = S_ADDR;
          gnt_d   = win1;
          addr_d  = win1 ? addr1  : addr0;
          wdata_d = win1 ? wdata1 : wdata0;
          we_d    = win1 ? we1    : we0;
          if (tie && FIXED_PRIO == 0)
            last_d = win1;
        end
      end
      S_ADDR:   state_d = S_ACCESS;
      S_ACCESS: begin
        state_d = S_DONE;
        if (!we_q)
          rdata_d = bus_in;
        ack0_d = ~gnt_q;
        ack1_d = gnt_q;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // Strobes are gated by rst so a reset landing in ACCESS never writes the RAM.
  assign ram_read  = !rst && (state_q == S_ACCESS) && !we_q;
  assign ram_write = !rst && (state_q == S_ACCESS) && we_q;
  assign bus_oe    = ram_write;
  assign ram_addr  = addr_q;
  assign bus_out   = wdata_q;
  assign rdata     = rdata_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic req0, we0, req1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic ack0, ack1, ram_read, ram_write, bus_oe, busy;
  logic [7:0] rdata, bus_out, bus_in;
  logic [3:0] ram_addr;
  logic f_ack0, f_ack1, f_ram_read, f_ram_write, f_bus_oe, f_busy;
  logic [7:0] f_rdata, f_bus_out, f_bus_in;
  logic [3:0] f_ram_addr;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic       pl_en;
  logic [3:0] pl_a;
  logic [7:0] pl_d;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRIO(0)) u0 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .busy(busy));

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .FIXED_PRIO(1)) u1 (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(f_ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(f_ack1),
    .rdata(f_rdata), .ram_addr(f_ram_addr), .ram_read(f_ram_read), .ram_write(f_ram_write),
    .bus_out(f_bus_out), .bus_oe(f_bus_oe), .bus_in(f_bus_in), .busy(f_busy));

  // Behavioural RAMs on each arbiter's bus.
  assign bus_in   = ram_read   ? mem0[ram_addr]   : (bus_oe   ? bus_out   : 8'h00);
  assign f_bus_in = f_ram_read ? mem1[f_ram_addr] : (f_bus_oe ? f_bus_out : 8'h00);

  always @(posedge clk) begin
    if (ram_write) mem0[ram_addr] <= bus_out;
    else if (pl_en) mem0[pl_a] <= pl_d;
    if (f_ram_write) mem1[f_ram_addr] <= f_bus_out;
    else if (pl_en) mem1[pl_a] <= pl_d;
  end

  task automatic clear_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; clear_inputs();
    @(negedge clk);
    checks++;
    if ({ram_addr, rdata, bus_out} !== 20'h0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0", {ram_addr, rdata, bus_out});
    end
    checks++;
    if ({ack0, ack1, busy, ram_read, ram_write, bus_oe} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {ack0, ack1, busy, ram_read, ram_write, bus_oe});
    end
    rst = 0;
  endtask

  task automatic test_read_basic();
    int rd_cnt;
    do_reset();
    preload(4'd3, 8'h90);
    req0 = 1; we0 = 0; addr0 = 4'd3;
    rd_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rd_cnt += int'(ram_read);
      if (k == 1) begin
        checks++;
        if (ram_addr !== 4'd3) begin errors++; $display("FAIL rd_addr: got %h expected 3", ram_addr); end
      end
      checks++;
      if (ack0 !== (k == 3) || ack1 !== 1'b0) begin
        errors++; $display("FAIL rd_ack k=%0d: got %b%b expected %b0", k, ack0, ack1, k == 3);
      end
      if (k == 3) begin
        checks++;
        if (rdata !== 8'h90) begin errors++; $display("FAIL rd_data: got %h expected 90", rdata); end
        req0 = 0;
      end
    end
    checks++;
    if (rd_cnt != 1) begin errors++; $display("FAIL rd_strobe_len: got %0d expected 1", rd_cnt); end
  endtask

  task automatic test_write_then_read();
    do_reset();
    req1 = 1; we1 = 1; addr1 = 4'd7; wdata1 = 8'hA5;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 2) begin
        checks++;
        if ({ram_write, bus_oe, ram_read, bus_out} !== {3'b110, 8'hA5}) begin
          errors++; $display("FAIL wr_access: got %b%b%b/%h expected 110/a5", ram_write, bus_oe, ram_read, bus_out);
        end
      end
      checks++;
      if (ack1 !== (k == 3) || ack0 !== 1'b0) begin
        errors++; $display("FAIL wr_ack k=%0d: got %b%b expected 0%b", k, ack0, ack1, k == 3);
      end
      if (k == 3) req1 = 0;
    end
    checks++;
    if (mem0[7] !== 8'hA5) begin errors++; $display("FAIL wr_mem: got %h expected a5", mem0[7]); end
    req0 = 1; we0 = 0; addr0 = 4'd7;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        checks++;
        if (ack0 !== 1'b1 || rdata !== 8'hA5) begin
          errors++; $display("FAIL wr_readback: got ack=%b data=%h expected ack=1 data=a5", ack0, rdata);
        end
        req0 = 0;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_a;
    do_reset();
    preload(4'd1, 8'h5A);
    preload(4'd2, 8'hC3);
    req0 = 1; we0 = 0; addr0 = 4'd1;
    req1 = 1; we1 = 0; addr1 = 4'd2;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      checks++;
      if (ack0 !== (c % 8 == 3) || ack1 !== (c % 8 == 7)) begin
        errors++; $display("FAIL rr_ack c=%0d: got %b%b expected %b%b", c, ack0, ack1, c % 8 == 3, c % 8 == 7);
      end
      if (c % 4 != 0) begin
        exp_a = (c % 8 < 4) ? 4'd1 : 4'd2;
        checks++;
        if (ram_addr !== exp_a) begin errors++; $display("FAIL rr_addr c=%0d: got %h expected %h", c, ram_addr, exp_a); end
      end
      if (c % 4 == 3) begin
        checks++;
        if (rdata !== ((c % 8 == 3) ? 8'h5A : 8'hC3)) begin
          errors++; $display("FAIL rr_data c=%0d: got %h expected %h", c, rdata, (c % 8 == 3) ? 8'h5A : 8'hC3);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_fixed_prio();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 4'd1;
    req1 = 1; we1 = 0; addr1 = 4'd2;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if (c <= 15) begin
        if (f_ack0 !== (c % 4 == 3) || f_ack1 !== 1'b0) begin
          errors++; $display("FAIL fp_ack c=%0d: got %b%b expected %b0", c, f_ack0, f_ack1, c % 4 == 3);
        end
      end else if (f_ack1 !== (c == 19) || f_ack0 !== 1'b0) begin
        errors++; $display("FAIL fp_ack1 c=%0d: got %b%b expected 0%b", c, f_ack0, f_ack1, c == 19);
      end
      if (c == 15) req0 = 0;
      if (c == 19) req1 = 0;
    end
  endtask

  task automatic test_reset_in_access();
    int stray;
    do_reset();
    preload(4'd5, 8'h11);
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 8'h3C;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ram_write !== 1'b1) begin errors++; $display("FAIL rsta_pre: got ram_write=%b expected 1", ram_write); end
    rst = 1; req0 = 0;
    #1;
    checks++;
    if ({ram_write, bus_oe, ram_read} !== 3'b000) begin
      errors++; $display("FAIL rsta_gate: got %b expected 000", {ram_write, bus_oe, ram_read});
    end
    @(negedge clk);
    checks++;
    if ({ram_addr, rdata, bus_out, ack0, ack1, busy} !== 23'h0) begin
      errors++; $display("FAIL rsta_outs: got %h expected 0", {ram_addr, rdata, bus_out, ack0, ack1, busy});
    end
    checks++;
    if (mem0[5] !== 8'h11) begin errors++; $display("FAIL rsta_mem: got %h expected 11", mem0[5]); end
    rst = 0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      stray += int'(ack0) + int'(ack1);
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL rsta_noack: got %0d acks expected 0", stray); end
  endtask

  task automatic test_wait_midtxn();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 4'd4;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c != 4 && c != 8) || ram_read !== (c == 2 || c == 6) || ram_write !== 1'b0) begin
        errors++; $display("FAIL wait_ctrl c=%0d: got %b%b%b expected %b%b0", c, busy, ram_read, ram_write,
                           c != 4 && c != 8, c == 2 || c == 6);
      end
      checks++;
      if (ack0 !== (c == 3) || ack1 !== (c == 7)) begin
        errors++; $display("FAIL wait_ack c=%0d: got %b%b expected %b%b", c, ack0, ack1, c == 3, c == 7);
      end
      if (c == 5) begin
        checks++;
        if (ram_addr !== 4'd9) begin errors++; $display("FAIL wait_addr: got %h expected 9", ram_addr); end
      end
      if (c == 1) begin req1 = 1; we1 = 0; addr1 = 4'd9; end
      if (c == 3) req0 = 0;
      if (c == 7) req1 = 0;
    end
  endtask

  // Transaction-level model: one grant at a time, age counts cycles since the latch edge.
  task automatic test_random();
    logic [7:0] mmem [16];
    int         age;
    logic       mport, mwe, mlast, w1;
    logic [3:0] maddr;
    logic [7:0] mwd, exp_rd;
    logic [5:0] exp_ctl;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      mmem[i] = 8'($urandom);
      preload(4'(i), mmem[i]);
    end
    age = 0; mlast = 1; exp_rd = 8'h00;
    mport = 0; mwe = 0; maddr = 0; mwd = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      exp_ctl = {age != 0, age == 2 && !mwe, age == 2 && mwe, age == 2 && mwe,
                 age == 3 && !mport, age == 3 && mport};
      checks++;
      if ({busy, ram_read, ram_write, bus_oe, ack0, ack1} !== exp_ctl) begin
        errors++; $display("FAIL rand_ctl cyc=%0d: got %b expected %b", cyc,
                           {busy, ram_read, ram_write, bus_oe, ack0, ack1}, exp_ctl);
      end
      checks++;
      if (rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata cyc=%0d: got %h expected %h", cyc, rdata, exp_rd); end
      if (age != 0) begin
        checks++;
        if (ram_addr !== maddr || (age == 2 && mwe && bus_out !== mwd)) begin
          errors++; $display("FAIL rand_addr cyc=%0d: got %h/%h expected %h/%h", cyc, ram_addr, bus_out, maddr, mwd);
        end
      end
      // Requesters: drop on ack, scramble fields once latched, otherwise maybe raise.
      if (age == 3 && !mport) req0 = 0;
      else if (req0 && age != 0 && !mport) begin we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = 8'($urandom); end
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = 8'($urandom);
      end
      if (age == 3 && mport) req1 = 0;
      else if (req1 && age != 0 && mport) begin we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = 8'($urandom); end
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = 8'($urandom);
      end
      if (age == 3) age = 0;
      else if (age != 0) begin
        if (age == 2) begin
          if (mwe) mmem[maddr] = mwd;
          else exp_rd = mmem[maddr];
        end
        age++;
      end else if (req0 || req1) begin
        if (req0 && req1) begin w1 = !mlast; mlast = w1; end
        else w1 = req1;
        mport = w1;
        mwe   = w1 ? we1 : we0;
        maddr = w1 ? addr1 : addr0;
        mwd   = w1 ? wdata1 : wdata0;
        age   = 1;
      end
    end
    clear_inputs();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem0[i] !== mmem[i]) begin errors++; $display("FAIL rand_mem[%0d]: got %h expected %h", i, mem0[i], mmem[i]); end
    end
  endtask

  initial begin
    rst = 1; pl_en = 0; pl_a = 0; pl_d = 0;
    clear_inputs();
    test_reset();
    test_read_basic();
    test_write_then_read();
    test_round_robin();
    test_fixed_prio();
    test_reset_in_access();
    test_wait_midtxn();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
